// File: rtl/fe_pkg.sv
// Shared constants, FSM state type and order clamp for the multi-order FLAC fixed encoder.
package fe_pkg;

  localparam int unsigned MAX_ORDER = 4;
  localparam int unsigned ORDER_W   = 3;
  localparam int unsigned GROWTH    = 4;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } state_e;

  // Orders above the largest fixed predictor fall back to it.
  function automatic logic [ORDER_W-1:0] clamp_order(input logic [ORDER_W-1:0] order);
    return (order > ORDER_W'(MAX_ORDER)) ? ORDER_W'(MAX_ORDER) : order;
  endfunction

endpackage

// File: rtl/fe_history.sv
// Five-tap sample history; a clear loads the new sample and zeroes all older taps.
module fe_history
  import fe_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                               iClock,
  input  logic                               iResetN,
  input  logic                               iEnable,
  input  logic                               iClear,
  input  logic [SAMPLE_W-1:0]                iSample,
  output logic [MAX_ORDER:0][SAMPLE_W-1:0]   oTaps
);

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oTaps <= '0;
    end else if (iEnable) begin
      oTaps[0] <= iSample;
      for (int i = 1; i <= int'(MAX_ORDER); i++) begin
        oTaps[i] <= iClear ? '0 : oTaps[i-1];
      end
    end
  end

endmodule

// File: rtl/fixed_encoder_multi.sv
// FLAC fixed-predictor residual encoder, orders 0..4, three-stage pipeline.
// Define FE_ABS_SUM_EN to add the per-frame saturating sum of |residual| (oAbsSum/oSumValid).
module fixed_encoder_multi
  import fe_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int RES_W    = SAMPLE_W + GROWTH,
  parameter int LATENCY  = 3
) (
  input  logic                      iClock,
  input  logic                      iResetN,
  input  logic                      iValid,
  input  logic                      iFirst,
  input  logic                      iLast,
  input  logic [ORDER_W-1:0]        iOrder,
  input  logic [SAMPLE_W-1:0]       iSample,
  output logic                      oValid,
  output logic                      oWarmup,
  output logic                      oFirst,
  output logic                      oLast,
  output logic [ORDER_W-1:0]        oOrder,
  output logic signed [RES_W-1:0]   oResidual
`ifdef FE_ABS_SUM_EN
  ,
  output logic [RES_W+16-1:0]       oAbsSum,
  output logic                      oSumValid
`endif
);

  if (LATENCY != 3) begin : g_bad_latency
    $error("fixed_encoder_multi supports LATENCY == 3 only");
  end

  function automatic logic signed [RES_W-1:0] sext(input logic [SAMPLE_W-1:0] v);
    return {{(RES_W-SAMPLE_W){v[SAMPLE_W-1]}}, v};
  endfunction

  state_e               state_q;
  logic [ORDER_W-1:0]   order_q, cnt_q;
  logic                 accept, restart, warm_now;
  logic [ORDER_W-1:0]   ord_in, ord_now;

  logic                 s1_valid, s1_first, s1_last, s1_warmup;
  logic [ORDER_W-1:0]   s1_order;
  logic [MAX_ORDER:0][SAMPLE_W-1:0] taps;

  always_comb begin
    restart  = iValid & iFirst;
    accept   = iValid & (iFirst | (state_q != IDLE));
    ord_in   = clamp_order(iOrder);
    ord_now  = restart ? ord_in : order_q;
    warm_now = restart ? (ord_in != '0) : (state_q == WARMUP);
  end

  fe_history #(
    .SAMPLE_W (SAMPLE_W)
  ) u_history (
    .iClock  (iClock),
    .iResetN (iResetN),
    .iEnable (accept),
    .iClear  (restart),
    .iSample (iSample),
    .oTaps   (taps)
  );

  // Frame FSM plus stage 1 control; cnt_q counts warm-up samples already accepted.
  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state_q   <= IDLE;
      order_q   <= '0;
      cnt_q     <= '0;
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_warmup <= 1'b0;
      s1_order  <= '0;
    end else begin
      s1_valid  <= accept;
      s1_first  <= accept & iFirst;
      s1_last   <= accept & iLast;
      s1_warmup <= accept & warm_now;
      if (accept) s1_order <= ord_now;
      if (restart) begin
        order_q <= ord_in;
        cnt_q   <= ORDER_W'(1);
        if (iLast)                       state_q <= IDLE;
        else if (ord_in > ORDER_W'(1))   state_q <= WARMUP;
        else                             state_q <= RUN;
      end else if (accept) begin
        if (state_q == WARMUP) cnt_q <= cnt_q + ORDER_W'(1);
        if (iLast) begin
          state_q <= IDLE;
        end else if (state_q == WARMUP && (cnt_q + ORDER_W'(1)) == order_q) begin
          state_q <= RUN;
        end
      end
    end
  end

  // Stage 2: partial sums for every order, multiplies built from shifts and adds.
  logic signed [RES_W-1:0] a0, a1, a2, a3, a4;
  logic signed [RES_W-1:0] c1, c2, c3, c4;
  logic signed [RES_W-1:0] p0, p1, p2, p3, p4;
  logic                    s2_valid, s2_first, s2_last, s2_warmup;
  logic [ORDER_W-1:0]      s2_order;

  always_comb begin
    a0 = sext(taps[0]);
    a1 = sext(taps[1]);
    a2 = sext(taps[2]);
    a3 = sext(taps[3]);
    a4 = sext(taps[4]);
    c1 = a0 - a1;
    c2 = a0 - (a1 <<< 1) + a2;
    c3 = a0 - ((a1 <<< 1) + a1) + ((a2 <<< 1) + a2) - a3;
    c4 = a0 - (a1 <<< 2) + ((a2 <<< 2) + (a2 <<< 1)) - (a3 <<< 2) + a4;
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      s2_valid  <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      s2_warmup <= 1'b0;
      s2_order  <= '0;
      p0 <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_first  <= s1_first;
      s2_last   <= s1_last;
      s2_warmup <= s1_warmup;
      if (s1_valid) begin
        s2_order <= s1_order;
        p0 <= a0;
        p1 <= c1;
        p2 <= c2;
        p3 <= c3;
        p4 <= c4;
      end
    end
  end

  // Stage 3: order select and output register.
  logic signed [RES_W-1:0] sel;

  always_comb begin
    sel = p0;
    if (!s2_warmup) begin
      case (s2_order)
        3'd0:    sel = p0;
        3'd1:    sel = p1;
        3'd2:    sel = p2;
        3'd3:    sel = p3;
        default: sel = p4;
      endcase
    end
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oValid    <= 1'b0;
      oWarmup   <= 1'b0;
      oFirst    <= 1'b0;
      oLast     <= 1'b0;
      oOrder    <= '0;
      oResidual <= '0;
    end else begin
      oValid  <= s2_valid;
      oWarmup <= s2_warmup;
      oFirst  <= s2_first;
      oLast   <= s2_last;
      if (s2_valid) begin
        oOrder    <= s2_order;
        oResidual <= sel;
      end
    end
  end

`ifdef FE_ABS_SUM_EN
  localparam int SUM_W = RES_W + 16;

  logic [RES_W-1:0] mag;
  logic [SUM_W:0]   sum_ext;

  // Carry out of the extended add marks saturation.
  always_comb begin
    mag = oResidual[RES_W-1] ? -oResidual : oResidual;
    if (oWarmup) mag = '0;
    sum_ext = (oFirst ? '0 : {1'b0, oAbsSum}) + (SUM_W+1)'(mag);
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      oAbsSum   <= '0;
      oSumValid <= 1'b0;
    end else begin
      oSumValid <= oValid & oLast;
      if (oValid) oAbsSum <= sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
    end
  end
`endif

endmodule
